// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Fetch PC register and next-PC sequencing with branch, jump,
//               register-jump wait, mispredict recovery and external load.
// Revision    : 1.0
// ============================================================================
module fetch_sequencer #(
  parameter int PC_WIDTH      = 16,
  parameter int FETCH_WIDTH   = 4,
  parameter int RESET_PC      = 0,
  parameter int RECOV_BUBBLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_fetch,
  input  logic                has_mispredict,
  input  logic [PC_WIDTH-1:0] pc_recovery,
  input  logic                exter_pc_en,
  input  logic [PC_WIDTH-1:0] exter_pc,
  input  logic                brnch_taken,
  input  logic [1:0]          brnch_slot,
  input  logic [PC_WIDTH-1:0] brnch_target,
  input  logic                jump_imm_valid,
  input  logic [1:0]          jump_imm_slot,
  input  logic [PC_WIDTH-1:0] jump_imm_target,
  input  logic                jump_reg_pending,
  input  logic                jump_base_rdy_from_rf,
  input  logic [PC_WIDTH-1:0] jump_base_from_rf,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_valid,
  output logic [2:0]          pc_sel,
  output logic                stall_for_jump,
  output logic [7:0]          jr_stall_cnt
);

  localparam int c_bub_w = (RECOV_BUBBLES < 2) ? 1 : $clog2(RECOV_BUBBLES + 1);
  localparam logic [c_bub_w-1:0]  c_bub_init = c_bub_w'(RECOV_BUBBLES);
  localparam logic [c_bub_w-1:0]  c_bub_one  = c_bub_w'(1);
  localparam logic [PC_WIDTH-1:0] c_reset_pc = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] c_pc_inc   = PC_WIDTH'(FETCH_WIDTH);

  localparam logic [2:0] c_sel_seq   = 3'd0;
  localparam logic [2:0] c_sel_brnch = 3'd1;
  localparam logic [2:0] c_sel_jimm  = 3'd2;
  localparam logic [2:0] c_sel_jreg  = 3'd3;
  localparam logic [2:0] c_sel_recov = 3'd4;
  localparam logic [2:0] c_sel_ext   = 3'd5;
  localparam logic [2:0] c_sel_hold  = 3'd6;

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_RUN     = 2'd1,
    S_JR_WAIT = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_bub_w-1:0]   r_bub_cnt;

  logic                 w_take_jimm;
  logic                 w_take_brnch;
  logic [7:0]           w_jr_cnt_inc;

  // Both redirects in one bundle: the earlier slot wins, a tie goes to the jump.
  assign w_take_jimm  = jump_imm_valid && (!brnch_taken || (jump_imm_slot <= brnch_slot));
  assign w_take_brnch = brnch_taken && !w_take_jimm;
  assign w_jr_cnt_inc = (jr_stall_cnt == 8'hFF) ? 8'hFF : jr_stall_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_BOOT;
      r_bub_cnt      <= '0;
      pc             <= c_reset_pc;
      fetch_valid    <= 1'b0;
      pc_sel         <= c_sel_seq;
      stall_for_jump <= 1'b0;
      jr_stall_cnt   <= 8'd0;
    end else if (exter_pc_en) begin
      pc             <= exter_pc;
      pc_sel         <= c_sel_ext;
      r_state        <= S_RUN;
      fetch_valid    <= 1'b1;
      stall_for_jump <= 1'b0;
    end else if (has_mispredict) begin
      pc             <= pc_recovery;
      pc_sel         <= c_sel_recov;
      r_state        <= S_RECOVER;
      r_bub_cnt      <= c_bub_init;
      fetch_valid    <= 1'b0;
      stall_for_jump <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state     <= S_RUN;
          fetch_valid <= 1'b1;
        end
        S_RUN: begin
          if (stall_fetch) begin
            pc_sel <= c_sel_hold;
          end else if (w_take_jimm) begin
            pc     <= jump_imm_target;
            pc_sel <= c_sel_jimm;
          end else if (w_take_brnch) begin
            pc     <= brnch_target;
            pc_sel <= c_sel_brnch;
          end else if (jump_reg_pending) begin
            if (jump_base_rdy_from_rf) begin
              pc     <= jump_base_from_rf;
              pc_sel <= c_sel_jreg;
            end else begin
              // The first waiting cycle is already counted on entry.
              r_state        <= S_JR_WAIT;
              pc_sel         <= c_sel_hold;
              fetch_valid    <= 1'b0;
              stall_for_jump <= 1'b1;
              jr_stall_cnt   <= w_jr_cnt_inc;
            end
          end else begin
            pc     <= pc + c_pc_inc;
            pc_sel <= c_sel_seq;
          end
        end
        S_JR_WAIT: begin
          if (jump_base_rdy_from_rf) begin
            pc             <= jump_base_from_rf;
            pc_sel         <= c_sel_jreg;
            r_state        <= S_RUN;
            fetch_valid    <= 1'b1;
            stall_for_jump <= 1'b0;
          end else begin
            jr_stall_cnt <= w_jr_cnt_inc;
          end
        end
        S_RECOVER: begin
          if (r_bub_cnt <= c_bub_one) begin
            r_state     <= S_RUN;
            r_bub_cnt   <= '0;
            fetch_valid <= 1'b1;
          end else begin
            r_bub_cnt <= r_bub_cnt - c_bub_one;
          end
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer.
// Revision    : 1.0
// ============================================================================
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall_fetch;
  logic        has_mispredict;
  logic [15:0] pc_recovery;
  logic        exter_pc_en;
  logic [15:0] exter_pc;
  logic        brnch_taken;
  logic [1:0]  brnch_slot;
  logic [15:0] brnch_target;
  logic        jump_imm_valid;
  logic [1:0]  jump_imm_slot;
  logic [15:0] jump_imm_target;
  logic        jump_reg_pending;
  logic        jump_base_rdy_from_rf;
  logic [15:0] jump_base_from_rf;
  logic [15:0] pc;
  logic        fetch_valid;
  logic [2:0]  pc_sel;
  logic        stall_for_jump;
  logic [7:0]  jr_stall_cnt;

  int n_tests;
  int n_fail;

  fetch_sequencer #(
    .PC_WIDTH      (16),
    .FETCH_WIDTH   (4),
    .RESET_PC      (0),
    .RECOV_BUBBLES (2)
  ) u_dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .stall_fetch           (stall_fetch),
    .has_mispredict        (has_mispredict),
    .pc_recovery           (pc_recovery),
    .exter_pc_en           (exter_pc_en),
    .exter_pc              (exter_pc),
    .brnch_taken           (brnch_taken),
    .brnch_slot            (brnch_slot),
    .brnch_target          (brnch_target),
    .jump_imm_valid        (jump_imm_valid),
    .jump_imm_slot         (jump_imm_slot),
    .jump_imm_target       (jump_imm_target),
    .jump_reg_pending      (jump_reg_pending),
    .jump_base_rdy_from_rf (jump_base_rdy_from_rf),
    .jump_base_from_rf     (jump_base_from_rf),
    .pc                    (pc),
    .fetch_valid           (fetch_valid),
    .pc_sel                (pc_sel),
    .stall_for_jump        (stall_for_jump),
    .jr_stall_cnt          (jr_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_fetch           = 1'b0;
    has_mispredict        = 1'b0;
    pc_recovery           = 16'h0;
    exter_pc_en           = 1'b0;
    exter_pc              = 16'h0;
    brnch_taken           = 1'b0;
    brnch_slot            = 2'd0;
    brnch_target          = 16'h0;
    jump_imm_valid        = 1'b0;
    jump_imm_slot         = 2'd0;
    jump_imm_target       = 16'h0;
    jump_reg_pending      = 1'b0;
    jump_base_rdy_from_rf = 1'b0;
    jump_base_from_rf     = 16'h0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},  32'(pc), 32'h0);
    check({tag, "_fv"},  32'(fetch_valid), 32'h0);
    check({tag, "_sel"}, 32'(pc_sel), 32'h0);
    check({tag, "_sfj"}, 32'(stall_for_jump), 32'h0);
    check({tag, "_cnt"}, 32'(jr_stall_cnt), 32'h0);
  endtask

  task automatic load_pc(input logic [15:0] val);
    exter_pc_en = 1'b1;
    exter_pc    = val;
    step();
    exter_pc_en = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    check_reset("rst");

    // T1: boot then sequential advance
    rst_n = 1'b1;
    check("t1_boot_fv", 32'(fetch_valid), 32'h0);
    step();
    check("t1_pc0", 32'(pc), 32'h0);
    check("t1_fv", 32'(fetch_valid), 32'h1);
    step();
    check("t1_pc4", 32'(pc), 32'h4);
    step();
    check("t1_pc8", 32'(pc), 32'h8);
    step();
    check("t1_pcC", 32'(pc), 32'hC);
    check("t1_sel", 32'(pc_sel), 32'h0);
    step();
    check("t2_pc10", 32'(pc), 32'h10);

    // T2: branch and jump in the same bundle
    brnch_taken = 1'b1; brnch_slot = 2'd2; brnch_target = 16'h0040;
    jump_imm_valid = 1'b1; jump_imm_slot = 2'd1; jump_imm_target = 16'h0080;
    step();
    check("t2_pc_jimm", 32'(pc), 32'h80);
    check("t2_sel_jimm", 32'(pc_sel), 32'h2);
    brnch_slot = 2'd0; jump_imm_slot = 2'd3; jump_imm_target = 16'h0090;
    step();
    check("t2_pc_brnch", 32'(pc), 32'h40);
    check("t2_sel_brnch", 32'(pc_sel), 32'h1);
    brnch_slot = 2'd1; jump_imm_slot = 2'd1;
    step();
    check("t2_pc_tie", 32'(pc), 32'h90);
    idle_inputs();

    // T3: register jump waits three cycles for its base
    load_pc(16'h0020);
    check("t3_pc_ext", 32'(pc), 32'h20);
    jump_reg_pending = 1'b1;
    step();
    jump_reg_pending = 1'b0;
    check("t3_sfj1", 32'(stall_for_jump), 32'h1);
    check("t3_cnt1", 32'(jr_stall_cnt), 32'h1);
    check("t3_fv_wait", 32'(fetch_valid), 32'h0);
    check("t3_pc_hold", 32'(pc), 32'h20);
    step();
    check("t3_cnt2", 32'(jr_stall_cnt), 32'h2);
    stall_fetch = 1'b1;
    step();
    check("t3_cnt3", 32'(jr_stall_cnt), 32'h3);
    check("t3_sfj3", 32'(stall_for_jump), 32'h1);
    jump_base_rdy_from_rf = 1'b1; jump_base_from_rf = 16'h1234;
    step();
    idle_inputs();
    check("t3_pc_jreg", 32'(pc), 32'h1234);
    check("t3_sel_jreg", 32'(pc_sel), 32'h3);
    check("t3_fv_run", 32'(fetch_valid), 32'h1);
    check("t3_sfj_off", 32'(stall_for_jump), 32'h0);
    check("t3_cnt_kept", 32'(jr_stall_cnt), 32'h3);
    jump_reg_pending = 1'b1; jump_base_rdy_from_rf = 1'b1; jump_base_from_rf = 16'h2000;
    step();
    idle_inputs();
    check("t3_pc_jreg_now", 32'(pc), 32'h2000);
    check("t3_fv_jreg_now", 32'(fetch_valid), 32'h1);

    // T4: mispredict aborts JR_WAIT; second mispredict restarts recovery
    jump_reg_pending = 1'b1;
    step();
    jump_reg_pending = 1'b0;
    check("t4_cnt4", 32'(jr_stall_cnt), 32'h4);
    has_mispredict = 1'b1; pc_recovery = 16'h0100;
    step();
    has_mispredict = 1'b0;
    check("t4_pc_recov", 32'(pc), 32'h100);
    check("t4_sel_recov", 32'(pc_sel), 32'h4);
    check("t4_sfj_abort", 32'(stall_for_jump), 32'h0);
    check("t4_fv_b0", 32'(fetch_valid), 32'h0);
    step();
    check("t4_fv_b1", 32'(fetch_valid), 32'h0);
    check("t4_pc_held", 32'(pc), 32'h100);
    has_mispredict = 1'b1; pc_recovery = 16'h0200;
    step();
    has_mispredict = 1'b0;
    check("t4_pc_recov2", 32'(pc), 32'h200);
    check("t4_fv_r0", 32'(fetch_valid), 32'h0);
    step();
    check("t4_fv_r1", 32'(fetch_valid), 32'h0);
    step();
    check("t4_fv_r2", 32'(fetch_valid), 32'h1);
    check("t4_pc_r2", 32'(pc), 32'h200);
    step();
    check("t4_pc_seq", 32'(pc), 32'h204);

    // T5: stall holds the PC and ignores a pending branch
    load_pc(16'h0008);
    stall_fetch = 1'b1;
    brnch_taken = 1'b1; brnch_slot = 2'd0; brnch_target = 16'h0400;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_pc_hold", 32'(pc), 32'h8);
      check("t5_sel_hold", 32'(pc_sel), 32'h6);
    end
    stall_fetch = 1'b0;
    step();
    idle_inputs();
    check("t5_pc_brnch", 32'(pc), 32'h400);
    check("t5_sel_brnch", 32'(pc_sel), 32'h1);

    // T6: wrap, external-load priority, asynchronous reset in JR_WAIT
    load_pc(16'hFFFC);
    step();
    check("t6_wrap", 32'(pc), 32'h0);
    check("t6_wrap_sel", 32'(pc_sel), 32'h0);
    exter_pc_en = 1'b1; exter_pc = 16'h0500;
    has_mispredict = 1'b1; pc_recovery = 16'h0700;
    step();
    idle_inputs();
    check("t6_ext_pc", 32'(pc), 32'h500);
    check("t6_ext_sel", 32'(pc_sel), 32'h5);
    check("t6_ext_fv", 32'(fetch_valid), 32'h1);
    jump_reg_pending = 1'b1;
    step();
    check("t6_sfj", 32'(stall_for_jump), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("t6_arst");
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();
    check("t6_after_pc", 32'(pc), 32'h0);
    check("t6_after_fv", 32'(fetch_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
